// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the serial-in/parallel-out receiver.
//   - sipo_state_e   : receive FSM states
//   - SIPO_*_DEF     : default word width and buffer depth
//   - sipo_ptr_width : buffer pointer width for a given depth
package sipo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } sipo_state_e;

    localparam int SIPO_WIDTH_DEF = 8;
    localparam int SIPO_DEPTH_DEF = 4;

    // A single-entry buffer still needs one pointer bit.
    function automatic int sipo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sipo_buf.sv
// sipo_buf: DEPTH x WIDTH single-clock word buffer for the receiver.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, wdata       : write request and word
//   pop               : read request; rdata is loaded on the same edge
//   rdata             : last popped word (registered, holds on empty pop)
//   empty, full       : occupancy flags from the registered pointers
//   rd_error          : one-cycle pulse, pop while empty
//   ovf_error         : one-cycle pulse, push dropped because full
import sipo_pkg::*;

module sipo_buf #(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter int DEPTH     = SIPO_DEPTH_DEF,
    parameter int PTR_WIDTH = sipo_ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             rd_error,
    output logic             ovf_error
);

    logic [WIDTH-1:0] mem [DEPTH];

    // {toggle, pointer}: a plain increment flips the toggle exactly when the
    // pointer wraps from DEPTH-1 to 0 (DEPTH is a power of two).
    logic [PTR_WIDTH:0]   wr_cnt;
    logic [PTR_WIDTH:0]   rd_cnt;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign wr_ptr = wr_cnt[PTR_WIDTH-1:0];
    assign rd_ptr = rd_cnt[PTR_WIDTH-1:0];

    assign empty = (wr_ptr == rd_ptr) && (wr_cnt[PTR_WIDTH] == rd_cnt[PTR_WIDTH]);
    assign full  = (wr_ptr == rd_ptr) && (wr_cnt[PTR_WIDTH] != rd_cnt[PTR_WIDTH]);

    // A push against a full buffer is dropped even when a pop frees a slot
    // on the same edge; full is judged before the edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rdata     <= '0;
            rd_error  <= 1'b0;
            ovf_error <= 1'b0;
        end else begin
            rd_error  <= pop && empty;
            ovf_error <= push && full;
            if (do_push) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (do_pop) begin
                rdata  <= mem[rd_ptr];
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: framed serial-in/parallel-out receiver with output buffer.
// Assembles WIDTH-bit words from a strobed bit stream (sstart_i marks the
// first bit) and queues them in sipo_buf for a read-enable consumer.
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   sdata_i/svalid_i/sstart_i : serial bit, bit strobe, first-bit marker
//   rd_en_i, rdata_o        : pop request, popped word (valid next cycle)
//   empty_o, full_o         : buffer occupancy flags
//   rd_error_o, ovf_error_o : pop-on-empty / drop-on-full pulses
//   frame_err_o             : sstart_i seen while a word was in progress
//   parity_err_o            : even-parity mismatch (0 when parity is off)
// Build option: define SIPO_PARITY_EN to expect one even-parity bit after
// each word; mismatching words are discarded.
import sipo_pkg::*;

module sipo_deserializer #(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter int DEPTH     = SIPO_DEPTH_DEF,
    parameter int PTR_WIDTH = sipo_ptr_width(DEPTH),
    parameter int MSB_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             sdata_i,
    input  logic             svalid_i,
    input  logic             sstart_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             rd_error_o,
    output logic             ovf_error_o,
    output logic             frame_err_o,
    output logic             parity_err_o
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sipo_state_e      state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] shift_word;
    logic [WIDTH-1:0] push_data;
    logic             push;
    logic             data_bit;

    // A strobed bit that is not a start marker continues the current word.
    assign data_bit = svalid_i && !sstart_i;

    // The first bit is placed so that WIDTH-1 further shifts carry it to
    // bit WIDTH-1 (MSB-first) or bit 0 (LSB-first).
    always_comb begin
        first_word = '0;
        if (MSB_FIRST != 0) begin
            first_word[0]       = sdata_i;
            shift_word          = {shreg[WIDTH-2:0], sdata_i};
        end else begin
            first_word[WIDTH-1] = sdata_i;
            shift_word          = {sdata_i, shreg[WIDTH-1:1]};
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_ok;

    // Word is held in shreg while the parity bit arrives.
    assign parity_ok = ((^shreg) ^ sdata_i) == 1'b0;
    assign push      = data_bit && (state == ST_PARITY) && parity_ok;
    assign push_data = shreg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= data_bit && (state == ST_PARITY) && !parity_ok;
        end
    end
`else
    // Push on the edge that samples the last data bit.
    assign push         = data_bit && (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
    assign push_data    = shift_word;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (svalid_i && sstart_i) begin
                // A start marker always begins a new word; any partial word
                // (data or awaiting parity) is abandoned.
                if (state != ST_IDLE) begin
                    frame_err_o <= 1'b1;
                end
                shreg   <= first_word;
                bit_cnt <= CNT_W'(1);
                state   <= ST_SHIFT;
            end else if (data_bit) begin
                case (state)
                    ST_SHIFT: begin
                        shreg   <= shift_word;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                            state <= ST_PARITY;
`else
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
`endif
                        end
                    end
`ifdef SIPO_PARITY_EN
                    ST_PARITY: begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end
`endif
                    default: begin
                        // Unframed bits in IDLE are ignored.
                    end
                endcase
            end
        end
    end

    sipo_buf #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_buf (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (push),
        .wdata     (push_data),
        .pop       (rd_en_i),
        .rdata     (rdata_o),
        .empty     (empty_o),
        .full      (full_o),
        .rd_error  (rd_error_o),
        .ovf_error (ovf_error_o)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer: an MSB-first and an LSB-first instance
// share one stimulus stream; a queue-based word model predicts every output
// each cycle, and directed literal checks pin the model.
module tb_sipo_deserializer;

    localparam int W = 8;
    localparam int D = 4;
`ifdef SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sdata = 1'b0, svalid = 1'b0, sstart = 1'b0, rd_en = 1'b0;

    logic [W-1:0] rdata_m, rdata_l;
    logic empty_m, full_m, rderr_m, ovf_m, ferr_m, perr_m;
    logic empty_l, full_l, rderr_l, ovf_l, ferr_l, perr_l;

    sipo_deserializer #(.WIDTH(W), .DEPTH(D), .PTR_WIDTH(2), .MSB_FIRST(1)) dut_m (
        .clk_i(clk), .rst_n_i(rst_n), .sdata_i(sdata), .svalid_i(svalid),
        .sstart_i(sstart), .rd_en_i(rd_en), .rdata_o(rdata_m), .empty_o(empty_m),
        .full_o(full_m), .rd_error_o(rderr_m), .ovf_error_o(ovf_m),
        .frame_err_o(ferr_m), .parity_err_o(perr_m));

    sipo_deserializer #(.WIDTH(W), .DEPTH(D), .PTR_WIDTH(2), .MSB_FIRST(0)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .sdata_i(sdata), .svalid_i(svalid),
        .sstart_i(sstart), .rd_en_i(rd_en), .rdata_o(rdata_l), .empty_o(empty_l),
        .full_o(full_l), .rd_error_o(rderr_l), .ovf_error_o(ovf_l),
        .frame_err_o(ferr_l), .parity_err_o(perr_l));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    int           mode = 0;          // 0 between words, 1 collecting bits, 2 awaiting parity
    bit           wbits[$];
    logic [W-1:0] qm[$];
    logic [W-1:0] ql[$];
    logic [W-1:0] wm = '0, wl = '0;
    logic [W-1:0] e_rm = '0, e_rl = '0;
    bit e_rderr = 0, e_ovf = 0, e_ferr = 0, e_perr = 0;
    bit full_b, empty_b, do_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; wbits.delete(); qm.delete(); ql.delete();
            e_rm = '0; e_rl = '0;
            e_rderr = 0; e_ovf = 0; e_ferr = 0; e_perr = 0;
        end else begin
            full_b  = (qm.size() == D);
            empty_b = (qm.size() == 0);
            do_push = 0;
            e_rderr = 0; e_ovf = 0; e_ferr = 0; e_perr = 0;
            if (svalid) begin
                if (sstart) begin
                    e_ferr = (mode != 0);
                    wbits.delete();
                    wbits.push_back(sdata);
                    mode = 1;
                end else if (mode == 1) begin
                    wbits.push_back(sdata);
                    if (wbits.size() == W) begin
                        wm = '0; wl = '0;
                        for (int i = 0; i < W; i++) begin
                            wm = {wm[W-2:0], wbits[i]};
                            wl[i] = wbits[i];
                        end
                        if (PAR) mode = 2;
                        else begin mode = 0; do_push = 1; end
                    end
                end else if (mode == 2) begin
                    mode = 0;
                    if (((^wm) ^ sdata) == 1'b0) do_push = 1;
                    else e_perr = 1;
                end
            end
            if (rd_en) begin
                if (empty_b) e_rderr = 1;
                else begin e_rm = qm.pop_front(); e_rl = ql.pop_front(); end
            end
            if (do_push) begin
                if (full_b) e_ovf = 1;
                else begin qm.push_back(wm); ql.push_back(wl); end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cnt_ferr = 0, cnt_ovf = 0, cnt_rderr = 0, cnt_perr = 0;

    always @(negedge clk) begin
        chk("rdata_msb", 32'(rdata_m), 32'(e_rm));
        chk("rdata_lsb", 32'(rdata_l), 32'(e_rl));
        chk("empty", 32'(empty_m), 32'(qm.size() == 0));
        chk("full", 32'(full_m), 32'(qm.size() == D));
        chk("empty_lsb", 32'(empty_l), 32'(ql.size() == 0));
        chk("rd_error", 32'(rderr_m), 32'(e_rderr));
        chk("ovf_error", 32'(ovf_m), 32'(e_ovf));
        chk("frame_err", 32'(ferr_m), 32'(e_ferr));
        chk("frame_err_lsb", 32'(ferr_l), 32'(e_ferr));
        chk("parity_err", 32'(perr_m), 32'(e_perr));
        if (ferr_m) cnt_ferr++;
        if (ovf_m) cnt_ovf++;
        if (rderr_m) cnt_rderr++;
        if (perr_m) cnt_perr++;
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // b[W-1] is sent first; sstart on that first bit.
    task automatic send_bits(input logic [W-1:0] b);
        for (int i = W - 1; i >= 0; i--) begin
            sstart = (i == W - 1);
            svalid = 1'b1;
            sdata  = b[i];
            tick();
        end
        svalid = 1'b0; sstart = 1'b0; sdata = 1'b0;
    endtask

    task automatic rd;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        repeat (3) tick();
        chk("rst_empty", 32'(empty_m), 32'd1);
        chk("rst_full", 32'(full_m), 32'd0);
        chk("rst_rdata", 32'(rdata_m), 32'd0);
        rst_n = 1'b1;
        tick();

        // 0xA5 MSB-first; palindrome bit pattern gives 0xA5 LSB-first too
        send_bits(8'hA5);
        chk("a5_not_empty", 32'(empty_m), 32'd0);
        rd();
        chk("a5_rdata_msb", 32'(rdata_m), 32'h A5);
        chk("a5_rdata_lsb", 32'(rdata_l), 32'h A5);
        chk("a5_empty_after", 32'(empty_m), 32'd1);

        // bit sequence 1,0,0,0,0,0,0,0
        send_bits(8'h80);
        rd();
        chk("one_rdata_lsb", 32'(rdata_l), 32'h01);
        chk("one_rdata_msb", 32'(rdata_m), 32'h80);

        // fill, overflow, drain, underflow (words back-to-back)
        for (int k = 0; k < 5; k++) begin
            v = 8'h11 + 8'(k);
            send_bits(v);
            if (k == 3) chk("full_after_4", 32'(full_m), 32'd1);
        end
        tick();
        chk("ovf_count", 32'(cnt_ovf), 32'd1);
        chk("full_after_5", 32'(full_m), 32'd1);
        for (int k = 0; k < 4; k++) begin
            rd();
            chk("drain_rdata", 32'(rdata_m), 32'h11 + 32'(k));
        end
        rd();
        tick();
        chk("rderr_count", 32'(cnt_rderr), 32'd1);
        chk("rderr_rdata_hold", 32'(rdata_m), 32'h14);

        // restart after 3 bits, then a full 0x3C
        for (int i = 0; i < 3; i++) begin
            sstart = (i == 0); svalid = 1'b1; sdata = 1'b1;
            tick();
        end
        send_bits(8'h3C);
        tick();
        chk("frame_count", 32'(cnt_ferr), 32'd1);
        rd();
        chk("frame_rdata", 32'(rdata_m), 32'h3C);
        chk("frame_only_one", 32'(empty_m), 32'd1);

`ifdef SIPO_PARITY_EN
        send_bits(8'h0F);
        svalid = 1'b1; sdata = 1'b0; tick();
        svalid = 1'b0;
        chk("par_ok_queued", 32'(empty_m), 32'd0);
        rd();
        chk("par_ok_rdata", 32'(rdata_m), 32'h0F);
        send_bits(8'h0F);
        svalid = 1'b1; sdata = 1'b1; tick();
        svalid = 1'b0; sdata = 1'b0;
        tick();
        chk("par_err_count", 32'(cnt_perr), 32'd1);
        chk("par_err_empty", 32'(empty_m), 32'd1);
`endif

        // asynchronous reset mid-word with two words queued
        send_bits(8'h21);
        send_bits(8'h22);
        v = 8'h77;
        for (int i = W - 1; i >= 3; i--) begin
            sstart = (i == W - 1); svalid = 1'b1; sdata = v[i];
            tick();
        end
        svalid = 1'b0; sstart = 1'b0;
        chk("pre_rst_queued", 32'(empty_m), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_empty", 32'(empty_m), 32'd1);
        chk("async_rst_rdata", 32'(rdata_m), 32'd0);
        chk("async_rst_full", 32'(full_m), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_bits(8'h77);
        rd();
        chk("post_rst_rdata", 32'(rdata_m), 32'h77);
        chk("post_rst_empty", 32'(empty_m), 32'd1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out receiver: the receive-side counterpart of the team's parallel-to-serial transmit path. Samples a framed serial bit stream, assembles WIDTH-bit words, and queues them in a small single-clock output buffer. The downstream consumer drains the buffer with a read-enable handshake. Runs entirely in one clock domain; any crossing is handled upstream.

## Interface
- WIDTH, 8: bits per assembled word.
- DEPTH, 4: output buffer entries; power of two, ≥2.
- PTR_WIDTH, 2: log2(DEPTH).
- MSB_FIRST, 1: 1 = first serial bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- sdata_i  input  1  serial data bit, sampled only when svalid_i=1.
- svalid_i  input  1  bit strobe; one bit consumed per cycle with svalid_i=1.
- sstart_i  input  1  qualifies the current svalid_i bit as the first bit of a word.
- rd_en_i  input  1  pop request from the consumer.
- rdata_o  output  WIDTH  popped word, registered.
- empty_o  output  1  buffer holds no words.
- full_o  output  1  buffer holds DEPTH words.
- rd_error_o  output  1  one-cycle pulse: pop attempted while empty.
- ovf_error_o  output  1  one-cycle pulse: completed word dropped because buffer full.
- frame_err_o  output  1  one-cycle pulse: sstart_i seen mid-word.
- parity_err_o  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with SIPO_PARITY_EN).
- IDLE: svalid_i=1 with sstart_i=0 is ignored. svalid_i=1 with sstart_i=1 loads the first bit, sets bit_cnt=1, and moves to SHIFT.
- SHIFT: each svalid_i=1 shifts in one bit per MSB_FIRST and increments bit_cnt. When bit_cnt reaches WIDTH, the word is complete: go to PARITY if enabled, otherwise push and return to IDLE. Cycles with svalid_i=0 hold all state; there is no timeout.
- Mid-word restart: sstart_i=1 with svalid_i=1 in SHIFT or PARITY pulses frame_err_o, discards the partial word, and treats the bit as a new first bit (bit_cnt=1, stay in or enter SHIFT).
- Push: the word is written at wr_ptr and wr_ptr increments. A toggle bit flips when the pointer wraps from DEPTH-1 to 0.
- Push while full (full_o sampled before the edge): the word is dropped, ovf_error_o pulses, and pointers are unchanged. This holds even if a pop occurs in the same cycle.
- Pop: rd_en_i=1 and empty_o=0 loads rdata_o from mem[rd_ptr] and increments rd_ptr, with the same toggle scheme. rd_en_i=1 with empty_o=1 pulses rd_error_o and leaves rdata_o unchanged.
- Status flags: full_o = (wr_ptr==rd_ptr) and toggles differ. empty_o = (wr_ptr==rd_ptr) and toggles equal. Both are derived combinationally from registered pointers.
- A simultaneous push and pop with the buffer neither empty nor full changes the occupancy by zero.

## Timing
- Reset values: rdata_o=0, empty_o=1, full_o=0, all error pulses 0. Pointers, toggles, bit_cnt and shift register are 0; FSM is in IDLE. Memory contents are don't-care.
- Reset assertion mid-word or with the buffer non-empty discards everything immediately (asynchronous). Deassertion is taken synchronously to clk_i.
- Latency, no parity: the edge that samples the last bit also writes the buffer. empty_o falls in the following cycle.
- Latency with parity: one extra svalid_i bit; the push happens on the edge that samples the parity bit.
- rdata_o is valid one cycle after the rd_en_i edge.
- Maximum sustained input: one bit per cycle, with back-to-back words allowed (sstart_i on the bit after the last bit).
- All error outputs are high for exactly one cycle per event.

## Configuration
- SIPO_PARITY_EN defined:
  - After WIDTH data bits, one even-parity bit is expected: XOR of data and parity bit must be 0.
  - On match, the word is pushed.
  - On mismatch, parity_err_o pulses, the word is not pushed, and the FSM returns to IDLE.
- SIPO_PARITY_EN undefined: there is no PARITY state, parity_err_o is constant 0, and every completed word is pushed.

## Structure
- Shared package sipo_pkg:
  - FSM state enum (ST_IDLE, ST_SHIFT, ST_PARITY).
  - Default WIDTH/DEPTH constants.
  - Function computing the pointer width from DEPTH.
- Single natural sub-module: sipo_buf, the DEPTH×WIDTH synchronous buffer with pointers, toggles, full/empty and rd_error. The top level holds the FSM, shift register and bit counter.

## Test plan
- Reset then send 0xA5 MSB-first (1,0,1,0,0,1,0,1), sstart_i on the first bit -> empty_o=0 the next cycle; rd_en_i gives rdata_o=0xA5 one cycle later; empty_o=1 afterwards.
- MSB_FIRST=0, same bit sequence -> rdata_o=0xA5 reversed = 0xA5 (palindrome check); then send 0x01 LSB-first (1,0,0,0,0,0,0,0) -> rdata_o=0x01.
- Send 5 words 0x11..0x15 with no reads, DEPTH=4 -> full_o=1 after the 4th word; ovf_error_o pulses on the 5th; four reads return 0x11..0x14; 5th read pulses rd_error_o.
- sstart_i reasserted after 3 bits of a word, then a full 0x3C -> one frame_err_o pulse; only 0x3C is queued.
- With SIPO_PARITY_EN: 0x0F plus parity 0 -> queued. 0x0F plus parity 1 -> parity_err_o pulses and empty_o stays 1.
- rst_n_i pulled low after 5 of 8 bits with 2 words queued -> empty_o=1 and rdata_o=0 immediately; the next full word 0x77 is received correctly.
